axis_quadrature_tracker: RTL and testbench
==========================================

// Module: axis_quadrature_tracker
// PURPOSE
//  Next-generation interferometer fringe counter. Takes paired signed samples (A = low half, B = high half)
//  on AXI-Stream, squares each into a hysteresis bit, and decodes quadrature edges in x1/x2/x4 modes.
//  Outputs a signed, wrapping position with one output beat per consumed input beat.
//  Sits between the ADC/filter stream and the position/velocity downstream cores; adds backpressure,
//  illegal-transition detection and clear, which the first-generation tracker lacks.
// PARAMETERS
//  S_AXIS_TDATA_WIDTH  32  input beat width; two signed halves of S_AXIS_TDATA_WIDTH/2 bits each
//  M_AXIS_TDATA_WIDTH  32  position width, two's complement, wraps modulo 2^M_AXIS_TDATA_WIDTH
//  ERR_WIDTH           16  illegal-transition counter width, saturating
// PORTS
//  aclk             in   1      clock
//  aresetn          in   1      asynchronous active-low reset
//  lower_threshold  in   S/2    signed low hysteresis level, shared by A and B
//  upper_threshold  in   S/2    signed high hysteresis level, shared by A and B
//  log_scale        in   5      step = 1<<log_scale; values >= M_AXIS_TDATA_WIDTH clamp to M_AXIS_TDATA_WIDTH-1
//  mode             in   2      0 = x1, 1 = x2, 2 = x4, 3 = reserved (behaves as x1)
//  clear            in   1      synchronous; zeroes position and err_count
//  S_AXIS_tvalid    in   1      input beat valid
//  S_AXIS_tdata     in   S      {B, A}
//  S_AXIS_tready    out  1      input accept
//  M_AXIS_tready    in   1      downstream accept
//  M_AXIS_tvalid    out  1      output beat valid
//  M_AXIS_tdata     out  M      position after the corresponding input sample
//  err_count        out  ERR    number of illegal (simultaneous A and B) transitions
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): position=0, M_AXIS_tvalid=0, err_count=0, qa=qb=0, va=vb=0.
//  An in-flight beat is discarded on reset.
//  Handshake: single output register; S_AXIS_tready = ~M_AXIS_tvalid | M_AXIS_tready (0 while in reset).
//  A beat is consumed on S_AXIS_tvalid & S_AXIS_tready. M_AXIS_tvalid rises on the next cycle (latency 1).
//  tdata holds stable while tvalid & ~tready. No input samples are lost or duplicated.
//  Hysteresis (per channel x, on consume only):
//   - x > upper and !(x < lower): q=1, v=1.
//   - x < lower and !(x > upper): q=0, v=1.
//   - otherwise q holds.
//  Counting requires va & vb both before and after the sample; the first classification never counts.
//  Edges are taken from previous {qa,qb} vs new {qa,qb}. Forward sequence is 00->10->11->01->00.
//   - qa fall: x1/x2/x4; + if qb=1 else -.
//   - qa rise: x2/x4; + if qb=0 else -.
//   - qb rise: x4 only; + if qa=1 else -.
//   - qb fall: x4 only; + if qa=0 else -.
//   - qa and qb change on the same sample: illegal, in every mode. Position is unchanged;
//     err_count += 1, saturating at all-ones.
//  Arithmetic: position +/- step, modulo 2^M; no saturation.
//  clear with a consume in the same cycle: clear wins. Position=0 and err_count=0; q/v still update.
//  The output beat carries 0.
//  mode, log_scale and thresholds are sampled per consumed beat; changes apply from the next beat,
//  with no flush.
// STRUCTURE
//  axis_tracker_pkg: MODE_X1/MODE_X2/MODE_X4 constants, edge-direction encoding (STEP_NONE/FWD/REV/ILLEGAL).
//  Sub-module hysteresis_comparator (signed sample, thresholds, enable -> q, v), instantiated for A and B.
//  Top level: edge decoder, step/position datapath, error counter, output register.
// TESTING (thresholds -100/100, log_scale 0 unless noted; (A,B) per beat)
//  x1, (-200,-200),(200,-200),(200,200),(-200,200),(-200,-200) -> tdata 0,0,0,1,1
//  x4, same sequence -> 0,1,2,3,4; reversed sequence -> 0,-1,-2,-3,-4 (0xFFFFFFFC); err_count 0
//  x2, log_scale 3, same sequence -> 0,8,8,16,16; A at 50 between beats -> no change (hysteresis)
//  (-200,-200)->(200,200) -> position unchanged, err_count 1; clear=1 next beat -> tdata 0, err_count 0
//  Input tvalid held high, M_AXIS_tready low 3 cycles -> S_AXIS_tready low, tdata stable; 10 in = 10 out, in order
//  M_AXIS_TDATA_WIDTH=8, x4, 128 forward steps from 0 -> 0x7F then 0x80; aresetn pulse mid-stream -> tvalid 0, position 0

Source files
------------

// File: rtl/axis_tracker_pkg.sv
// Shared constants and the quadrature edge decoder for the fringe tracker.
package axis_tracker_pkg;

    localparam logic [1:0] MODE_X1 = 2'd0;
    localparam logic [1:0] MODE_X2 = 2'd1;
    localparam logic [1:0] MODE_X4 = 2'd2;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_dir_e;

    // Forward order of {qa,qb} is 00 -> 10 -> 11 -> 01 -> 00; reserved mode falls back to x1.
    function automatic step_dir_e decode_edge(input logic [1:0] mode,
                                              input logic qa_prev, input logic qb_prev,
                                              input logic qa_new,  input logic qb_new);
        step_dir_e dir;
        logic      x4_en;
        logic      x2_en;
        dir   = STEP_NONE;
        x4_en = (mode == MODE_X4);
        x2_en = (mode == MODE_X2) || x4_en;
        if ((qa_prev != qa_new) && (qb_prev != qb_new)) begin
            dir = STEP_ILLEGAL;
        end else if (qa_prev && !qa_new) begin
            dir = qb_prev ? STEP_FWD : STEP_REV;
        end else if (!qa_prev && qa_new) begin
            if (x2_en) dir = qb_prev ? STEP_REV : STEP_FWD;
        end else if (!qb_prev && qb_new) begin
            if (x4_en) dir = qa_prev ? STEP_FWD : STEP_REV;
        end else if (qb_prev && !qb_new) begin
            if (x4_en) dir = qa_prev ? STEP_REV : STEP_FWD;
        end
        return dir;
    endfunction

endpackage

// File: rtl/hysteresis_comparator.sv
// Squares one signed channel into a hysteresis bit; q/v only advance on enable.
module hysteresis_comparator #(
    parameter int W = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                enable,
    input  logic signed [W-1:0] sample,
    input  logic signed [W-1:0] lower_threshold,
    input  logic signed [W-1:0] upper_threshold,
    output logic                q,
    output logic                v,
    output logic                q_next,
    output logic                v_next
);

    logic above;
    logic below;

    always_comb begin
        above  = sample > upper_threshold;
        below  = sample < lower_threshold;
        q_next = q;
        v_next = v;
        if (above && !below) begin
            q_next = 1'b1;
            v_next = 1'b1;
        end else if (below && !above) begin
            q_next = 1'b0;
            v_next = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            q <= 1'b0;
            v <= 1'b0;
        end else if (enable) begin
            q <= q_next;
            v <= v_next;
        end
    end

endmodule

// File: rtl/axis_quadrature_tracker.sv
// AXI-Stream quadrature fringe counter: one position beat out per sample pair consumed.
module axis_quadrature_tracker
    import axis_tracker_pkg::*;
#(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int M_AXIS_TDATA_WIDTH = 32,
    parameter int ERR_WIDTH          = 16
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] lower_threshold,
    input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] upper_threshold,
    input  logic [4:0]                          log_scale,
    input  logic [1:0]                          mode,
    input  logic                                clear,
    input  logic                                S_AXIS_tvalid,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]       S_AXIS_tdata,
    output logic                                S_AXIS_tready,
    input  logic                                M_AXIS_tready,
    output logic                                M_AXIS_tvalid,
    output logic [M_AXIS_TDATA_WIDTH-1:0]       M_AXIS_tdata,
    output logic [ERR_WIDTH-1:0]                err_count
);

    localparam int HW = S_AXIS_TDATA_WIDTH / 2;
    localparam int MW = M_AXIS_TDATA_WIDTH;

    function automatic logic [MW-1:0] step_size(input logic [4:0] ls);
        logic [MW-1:0] one;
        one = MW'(1);
        if (int'(ls) >= MW) return one << (MW - 1);
        return one << ls;
    endfunction

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                 consume_p0;
    logic signed [HW-1:0] sample_a_p0;
    logic signed [HW-1:0] sample_b_p0;
    logic                 qa, va, qa_next, va_next;
    logic                 qb, vb, qb_next, vb_next;
    step_dir_e            dir_p0;
    logic                 count_en_p0;
    logic signed [MW-1:0] step_p0;
    logic signed [MW-1:0] position;
    logic signed [MW-1:0] pos_next_p0;
    logic [ERR_WIDTH-1:0] err_next_p0;
    logic                 vld_p1;
    logic signed [MW-1:0] tdata_p1;

    assign S_AXIS_tready = aresetn & (~vld_p1 | M_AXIS_tready);
    assign consume_p0    = S_AXIS_tvalid & S_AXIS_tready;
    assign sample_a_p0   = S_AXIS_tdata[HW-1:0];
    assign sample_b_p0   = S_AXIS_tdata[2*HW-1:HW];

    hysteresis_comparator #(.W(HW)) u_cmp_a (
        .aclk(aclk), .aresetn(aresetn), .enable(consume_p0), .sample(sample_a_p0),
        .lower_threshold(lower_threshold), .upper_threshold(upper_threshold),
        .q(qa), .v(va), .q_next(qa_next), .v_next(va_next)
    );

    hysteresis_comparator #(.W(HW)) u_cmp_b (
        .aclk(aclk), .aresetn(aresetn), .enable(consume_p0), .sample(sample_b_p0),
        .lower_threshold(lower_threshold), .upper_threshold(upper_threshold),
        .q(qb), .v(vb), .q_next(qb_next), .v_next(vb_next)
    );

    // Stage p0: edge decode and position/error update for the beat being consumed
    always_comb begin
        dir_p0      = decode_edge(mode, qa, qb, qa_next, qb_next);
        count_en_p0 = va & vb & va_next & vb_next;
        step_p0     = step_size(log_scale);
        pos_next_p0 = position;
        err_next_p0 = err_count;
        if (consume_p0 && count_en_p0) begin
            case (dir_p0)
                STEP_FWD:     pos_next_p0 = position + step_p0;
                STEP_REV:     pos_next_p0 = position - step_p0;
                STEP_ILLEGAL: err_next_p0 = sat_inc(err_count);
                default:      pos_next_p0 = position;
            endcase
        end
        if (clear) begin
            pos_next_p0 = '0;
            err_next_p0 = '0;
        end
    end

    // Stage p1: single output register; holds while downstream stalls
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            position  <= '0;
            err_count <= '0;
            vld_p1    <= 1'b0;
            tdata_p1  <= '0;
        end else begin
            position  <= pos_next_p0;
            err_count <= err_next_p0;
            if (consume_p0) begin
                vld_p1   <= 1'b1;
                tdata_p1 <= pos_next_p0;
            end else if (M_AXIS_tready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign M_AXIS_tvalid = vld_p1;
    assign M_AXIS_tdata  = tdata_p1;

endmodule

// File: tb/tb_axis_quadrature_tracker.sv
// Directed bench for axis_quadrature_tracker (32-bit and 8-bit position instances).
module tb_axis_quadrature_tracker;

    logic               aclk = 1'b0;
    logic               aresetn;
    logic signed [15:0] lower_threshold;
    logic signed [15:0] upper_threshold;
    logic [4:0]         log_scale;
    logic [1:0]         mode;
    logic               clear;
    logic               s_tvalid;
    logic [31:0]        s_tdata;
    logic               s_tready;
    logic               m_tready;
    logic               m_tvalid;
    logic [31:0]        m_tdata;
    logic [15:0]        err_count;
    logic               s_tready8;
    logic               m_tvalid8;
    logic [7:0]         m_tdata8;
    logic [15:0]        err8;

    int tests  = 0;
    int failed = 0;

    always #5 aclk = ~aclk;

    axis_quadrature_tracker #(.S_AXIS_TDATA_WIDTH(32), .M_AXIS_TDATA_WIDTH(32), .ERR_WIDTH(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .lower_threshold(lower_threshold),
        .upper_threshold(upper_threshold), .log_scale(log_scale), .mode(mode), .clear(clear),
        .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(s_tready),
        .M_AXIS_tready(m_tready), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tdata(m_tdata),
        .err_count(err_count)
    );

    axis_quadrature_tracker #(.S_AXIS_TDATA_WIDTH(32), .M_AXIS_TDATA_WIDTH(8), .ERR_WIDTH(16)) dut8 (
        .aclk(aclk), .aresetn(aresetn), .lower_threshold(lower_threshold),
        .upper_threshold(upper_threshold), .log_scale(log_scale), .mode(mode), .clear(clear),
        .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(s_tready8),
        .M_AXIS_tready(m_tready), .M_AXIS_tvalid(m_tvalid8), .M_AXIS_tdata(m_tdata8),
        .err_count(err8)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  mode;
        logic [4:0]  ls;
        int          a;
        int          b;
        logic        clr;
        logic [31:0] exp_pos;
        logic [15:0] exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] md, input logic [4:0] ls,
                                input int a, input int b, input logic clr,
                                input logic [31:0] p, input logic [15:0] e);
        vec_t v;
        v.rst = rst; v.mode = md; v.ls = ls; v.a = a; v.b = b; v.clr = clr;
        v.exp_pos = p; v.exp_err = e;
        return v;
    endfunction

    function automatic logic [31:0] pack(input int a, input int b);
        logic [15:0] av;
        logic [15:0] bv;
        av = 16'(a);
        bv = 16'(b);
        return {bv, av};
    endfunction

    function automatic logic [31:0] fwd_beat(input int k);
        case (k % 4)
            0:       return pack(-200, -200);
            1:       return pack(200, -200);
            2:       return pack(200, 200);
            default: return pack(-200, 200);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        clear    = 1'b0;
        m_tready = 1'b1;
        #1;
        check("reset tvalid", 32'(m_tvalid), 32'd0);
        check("reset s_tready", 32'(s_tready), 32'd0);
        check("reset err", 32'(err_count), 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic apply(input logic [31:0] data, input logic clr);
        int waited;
        waited = 0;
        @(negedge aclk);
        s_tvalid = 1'b1;
        s_tdata  = data;
        clear    = clr;
        #1;
        while (!s_tready && waited < 20) begin
            @(negedge aclk);
            #1;
            waited++;
        end
        if (!s_tready) check("accept timeout", 32'(s_tready), 32'd1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int got;
        logic        hold_pending;
        logic [31:0] held;
        logic        in_fire;
        logic        out_fire;

        aresetn         = 1'b1;
        lower_threshold = -16'sd100;
        upper_threshold = 16'sd100;
        log_scale       = 5'd0;
        mode            = 2'd0;
        clear           = 1'b0;
        s_tvalid        = 1'b0;
        s_tdata         = '0;
        m_tready        = 1'b1;

        // x1
        vecs.push_back(mk(1, 0, 0, -200, -200, 0, 32'd0, 0));
        vecs.push_back(mk(0, 0, 0,  200, -200, 0, 32'd0, 0));
        vecs.push_back(mk(0, 0, 0,  200,  200, 0, 32'd0, 0));
        vecs.push_back(mk(0, 0, 0, -200,  200, 0, 32'd1, 0));
        vecs.push_back(mk(0, 0, 0, -200, -200, 0, 32'd1, 0));
        // x4 forward
        vecs.push_back(mk(1, 2, 0, -200, -200, 0, 32'd0, 0));
        vecs.push_back(mk(0, 2, 0,  200, -200, 0, 32'd1, 0));
        vecs.push_back(mk(0, 2, 0,  200,  200, 0, 32'd2, 0));
        vecs.push_back(mk(0, 2, 0, -200,  200, 0, 32'd3, 0));
        vecs.push_back(mk(0, 2, 0, -200, -200, 0, 32'd4, 0));
        // x4 reverse
        vecs.push_back(mk(1, 2, 0, -200, -200, 0, 32'd0, 0));
        vecs.push_back(mk(0, 2, 0, -200,  200, 0, 32'hFFFFFFFF, 0));
        vecs.push_back(mk(0, 2, 0,  200,  200, 0, 32'hFFFFFFFE, 0));
        vecs.push_back(mk(0, 2, 0,  200, -200, 0, 32'hFFFFFFFD, 0));
        vecs.push_back(mk(0, 2, 0, -200, -200, 0, 32'hFFFFFFFC, 0));
        // x2, step 8, hysteresis band
        vecs.push_back(mk(1, 1, 3, -200, -200, 0, 32'd0, 0));
        vecs.push_back(mk(0, 1, 3,  200, -200, 0, 32'd8, 0));
        vecs.push_back(mk(0, 1, 3,  200,  200, 0, 32'd8, 0));
        vecs.push_back(mk(0, 1, 3, -200,  200, 0, 32'd16, 0));
        vecs.push_back(mk(0, 1, 3, -200, -200, 0, 32'd16, 0));
        vecs.push_back(mk(0, 1, 3,   50, -200, 0, 32'd16, 0));
        vecs.push_back(mk(0, 1, 3,  200, -200, 0, 32'd24, 0));
        vecs.push_back(mk(0, 1, 3,   50, -200, 0, 32'd24, 0));
        // illegal transitions and clear
        vecs.push_back(mk(1, 2, 0, -200, -200, 0, 32'd0, 0));
        vecs.push_back(mk(0, 2, 0,  200,  200, 0, 32'd0, 1));
        vecs.push_back(mk(0, 2, 0,  200,  200, 1, 32'd0, 0));
        vecs.push_back(mk(0, 2, 0,  200, -200, 0, 32'hFFFFFFFF, 0));
        vecs.push_back(mk(0, 2, 0, -200,  200, 0, 32'hFFFFFFFF, 1));
        // reserved mode acts as x1
        vecs.push_back(mk(1, 3, 0, -200, -200, 0, 32'd0, 0));
        vecs.push_back(mk(0, 3, 0,  200, -200, 0, 32'd0, 0));
        vecs.push_back(mk(0, 3, 0,  200,  200, 0, 32'd0, 0));
        vecs.push_back(mk(0, 3, 0, -200,  200, 0, 32'd1, 0));
        vecs.push_back(mk(0, 3, 0, -200, -200, 0, 32'd1, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            mode      = vecs[i].mode;
            log_scale = vecs[i].ls;
            apply(pack(vecs[i].a, vecs[i].b), vecs[i].clr);
            check($sformatf("vec%0d tvalid", i), 32'(m_tvalid), 32'd1);
            check($sformatf("vec%0d tdata", i), m_tdata, vecs[i].exp_pos);
            check($sformatf("vec%0d err", i), 32'(err_count), 32'(vecs[i].exp_err));
        end

        // log_scale clamp on the 8-bit instance and top-bit step on the 32-bit one
        do_reset();
        mode      = 2'd2;
        log_scale = 5'd10;
        apply(fwd_beat(0), 1'b0);
        apply(fwd_beat(1), 1'b0);
        check("clamp pos32", m_tdata, 32'd1024);
        check("clamp pos8", 32'(m_tdata8), 32'h80);
        log_scale = 5'd31;
        apply(fwd_beat(2), 1'b0);
        check("ls31 pos32", m_tdata, 32'h80000400);
        check("ls31 pos8", 32'(m_tdata8), 32'h00);

        // backpressure: 10 beats in, 10 out, in order, output stable while stalled
        do_reset();
        mode         = 2'd2;
        log_scale    = 5'd0;
        sent         = 0;
        got          = 0;
        hold_pending = 1'b0;
        held         = '0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            @(negedge aclk);
            m_tready = (cyc >= 2 && cyc < 5) ? 1'b0 : (cyc % 3 != 1);
            s_tvalid = (sent < 10);
            s_tdata  = fwd_beat(sent);
            #1;
            if (hold_pending) check("stall tdata stable", m_tdata, held);
            if (m_tvalid && !m_tready) check("stall s_tready", 32'(s_tready), 32'd0);
            in_fire  = s_tvalid & s_tready;
            out_fire = m_tvalid & m_tready;
            if (out_fire) begin
                check($sformatf("stream beat%0d", got), m_tdata, 32'(got));
                got++;
            end
            hold_pending = m_tvalid & ~m_tready;
            held         = m_tdata;
            if (in_fire) sent++;
        end
        check("stream count out", 32'(got), 32'd10);
        check("stream count in", 32'(sent), 32'd10);
        @(negedge aclk);
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        // 8-bit wrap at 128 forward x4 steps
        do_reset();
        mode      = 2'd2;
        log_scale = 5'd0;
        for (int k = 0; k <= 128; k++) begin
            apply(fwd_beat(k), 1'b0);
            if (k == 127) begin
                check("wrap pos8 127", 32'(m_tdata8), 32'h7F);
                check("wrap pos32 127", m_tdata, 32'd127);
            end
            if (k == 128) begin
                check("wrap pos8 128", 32'(m_tdata8), 32'h80);
                check("wrap pos32 128", m_tdata, 32'd128);
            end
        end

        // reset pulse while a beat is offered
        @(negedge aclk);
        s_tvalid = 1'b1;
        s_tdata  = fwd_beat(129);
        aresetn  = 1'b0;
        #1;
        check("midreset tvalid", 32'(m_tvalid), 32'd0);
        check("midreset tvalid8", 32'(m_tvalid8), 32'd0);
        check("midreset s_tready", 32'(s_tready), 32'd0);
        @(negedge aclk);
        s_tvalid = 1'b0;
        aresetn  = 1'b1;
        apply(fwd_beat(1), 1'b0);
        check("postreset pos32", m_tdata, 32'd0);
        check("postreset pos8", 32'(m_tdata8), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
